// File: rtl/rf_dump_reader.sv
// Read-side sequencer for the register file: sweeps an address window two words per access
// and streams the captured words out over a valid/ready interface. Never writes the memory.
module rf_dump_reader #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [CW-1:0] count_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] rf_a1_o,
    output logic [AW-1:0] rf_a2_o,
    output logic          rf_rw_o,
    input  logic [DW-1:0] rf_rd1_i,
    input  logic [DW-1:0] rf_rd2_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [AW-1:0] out_addr_o,
    output logic          out_last_o
);

    typedef enum logic [2:0] {StIdle, StIssue, StCapture, StSendLo, StSendHi, StDone} state_e;

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    // Modular add; operands are always < DEPTH so one subtraction suffices.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {{(AW-1){1'b0}}, b};
        if (s >= DepthW) s = s - DepthW;
        return s[AW-1:0];
    endfunction

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] hold1_q, hold1_d;
    logic [DW-1:0] hold2_q, hold2_d;

    logic [AW-1:0] ptr_plus1, ptr_plus2;
    logic          is_last;

    assign ptr_plus1 = wrap_add(ptr_q, 2'd1);
    assign ptr_plus2 = wrap_add(ptr_q, 2'd2);
    assign is_last   = (remaining_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            hold1_q     <= '0;
            hold2_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            hold1_q     <= hold1_d;
            hold2_q     <= hold2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        hold1_d     = hold1_q;
        hold2_d     = hold2_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (count_i == '0) begin
                        state_d = StDone;
                    end else begin
                        ptr_d       = base_addr_i;
                        remaining_d = count_i;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: begin
                hold1_d = rf_rd1_i;
                hold2_d = rf_rd2_i;
                state_d = StSendLo;
            end
            StSendLo: begin
                if (out_ready_i) begin
                    remaining_d = remaining_q - CW'(1);
                    state_d     = is_last ? StDone : StSendHi;
                end
            end
            StSendHi: begin
                if (out_ready_i) begin
                    remaining_d = remaining_q - CW'(1);
                    ptr_d       = ptr_plus2;
                    state_d     = is_last ? StDone : StIssue;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != StIdle);
        done_o      = 1'b0;
        rf_a1_o     = '0;
        rf_a2_o     = '0;
        rf_rw_o     = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_addr_o  = '0;
        out_last_o  = 1'b0;
        unique case (state_q)
            StIssue, StCapture: begin
                rf_a1_o = ptr_q;
                rf_a2_o = ptr_plus1;
            end
            StSendLo: begin
                out_valid_o = 1'b1;
                out_data_o  = hold1_q;
                out_addr_o  = ptr_q;
                out_last_o  = is_last;
            end
            StSendHi: begin
                out_valid_o = 1'b1;
                out_data_o  = hold2_q;
                out_addr_o  = ptr_plus1;
                out_last_o  = is_last;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader with a registered-read register-file model.
module tb_rf_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [CW-1:0] count_i = '0;
    logic          busy_o, done_o, rf_rw_o;
    logic [AW-1:0] rf_a1_o, rf_a2_o;
    logic [DW-1:0] rf_rd1_i = '0;
    logic [DW-1:0] rf_rd2_i = '0;
    logic          out_valid_o, out_last_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] out_data_o;
    logic [AW-1:0] out_addr_o;

    logic [DW-1:0] mem [5];
    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    rf_dump_reader #(.DEPTH(5), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rf_a1_o     (rf_a1_o),
        .rf_a2_o     (rf_a2_o),
        .rf_rw_o     (rf_rw_o),
        .rf_rd1_i    (rf_rd1_i),
        .rf_rd2_i    (rf_rd2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk = ~clk;

    // Register file: 1-cycle registered read; out-of-range addresses read as X.
    always @(posedge clk) begin
        rf_rd1_i <= (rf_a1_o < 5) ? mem[rf_a1_o] : 'x;
        rf_rd2_i <= (rf_a2_o < 5) ? mem[rf_a2_o] : 'x;
        if (out_valid_o && out_ready_i) hs_cnt++;
        if (done_o) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"}, 32'(busy_o), 0);
        check({tag, ".done"}, 32'(done_o), 0);
        check({tag, ".a1"}, 32'(rf_a1_o), 0);
        check({tag, ".a2"}, 32'(rf_a2_o), 0);
        check({tag, ".rw"}, 32'(rf_rw_o), 0);
        check({tag, ".valid"}, 32'(out_valid_o), 0);
        check({tag, ".data"}, out_data_o, 0);
        check({tag, ".addr"}, 32'(out_addr_o), 0);
        check({tag, ".last"}, 32'(out_last_o), 0);
    endtask

    // Start a sweep and check the streamed words; pulse_at >= 0 re-pulses start mid-sweep.
    task automatic run_sweep(input string tag, input int base, input int cnt, input int pulse_at);
        int got = 0;
        int guard = 0;
        int hs0;
        int exp_addr;
        hs0 = hs_cnt;
        start_i = 1'b1;
        base_addr_i = AW'(base);
        count_i = CW'(cnt);
        tick();
        start_i = 1'b0;
        check({tag, ".busy"}, 32'(busy_o), 1);
        check({tag, ".a1"}, 32'(rf_a1_o), 32'(base));
        check({tag, ".a2"}, 32'(rf_a2_o), 32'((base + 1) % 5));
        check({tag, ".valid_e1"}, 32'(out_valid_o), 0);
        tick();
        check({tag, ".valid_e2"}, 32'(out_valid_o), 0);
        tick();
        check({tag, ".valid_first"}, 32'(out_valid_o), 1);
        while (got < cnt && guard < 200) begin
            if (out_valid_o) begin
                exp_addr = (base + got) % 5;
                check({tag, ".addr"}, 32'(out_addr_o), 32'(exp_addr));
                check({tag, ".data"}, out_data_o, 32'h1000_0000 + 32'(exp_addr));
                check({tag, ".last"}, 32'(out_last_o), 32'(got == cnt - 1));
                check({tag, ".rw"}, 32'(rf_rw_o), 0);
                got++;
            end
            start_i = (got == pulse_at);
            base_addr_i = (got == pulse_at) ? AW'(3) : AW'(base);
            tick();
            start_i = 1'b0;
            guard++;
        end
        check({tag, ".words"}, 32'(got), 32'(cnt));
        check({tag, ".handshakes"}, 32'(hs_cnt - hs0), 32'(cnt));
        check({tag, ".done"}, 32'(done_o), 1);
        check({tag, ".done_busy"}, 32'(busy_o), 1);
        tick();
        check({tag, ".done_end"}, 32'(done_o), 0);
        check({tag, ".busy_end"}, 32'(busy_o), 0);
        check({tag, ".valid_end"}, 32'(out_valid_o), 0);
    endtask

    initial begin
        int hs0;
        int dn0;
        for (int i = 0; i < 5; i++) mem[i] = 32'h1000_0000 + 32'(i);
        #2;
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("idle");

        // 1: full window from 0
        run_sweep("t1", 0, 5, -1);

        // 2: wrapping window
        run_sweep("t2", 3, 4, -1);

        // 3: back-pressure in SEND_HI
        hs0 = hs_cnt;
        start_i = 1'b1; base_addr_i = '0; count_i = CW'(2);
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("t3.lo_valid", 32'(out_valid_o), 1);
        check("t3.lo_data", out_data_o, 32'h1000_0000);
        check("t3.lo_last", 32'(out_last_o), 0);
        tick();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3.stall_valid", 32'(out_valid_o), 1);
            check("t3.stall_data", out_data_o, 32'h1000_0001);
            check("t3.stall_addr", 32'(out_addr_o), 1);
            check("t3.stall_last", 32'(out_last_o), 1);
            tick();
        end
        out_ready_i = 1'b1;
        check("t3.resume_data", out_data_o, 32'h1000_0001);
        tick();
        check("t3.done", 32'(done_o), 1);
        check("t3.handshakes", 32'(hs_cnt - hs0), 2);
        tick();
        check("t3.done_end", 32'(done_o), 0);

        // 4: zero count
        hs0 = hs_cnt;
        start_i = 1'b1; base_addr_i = AW'(2); count_i = '0;
        tick();
        start_i = 1'b0;
        check("t4.done", 32'(done_o), 1);
        check("t4.busy", 32'(busy_o), 1);
        check("t4.valid", 32'(out_valid_o), 0);
        tick();
        check("t4.done_end", 32'(done_o), 0);
        check("t4.busy_end", 32'(busy_o), 0);
        check("t4.handshakes", 32'(hs_cnt - hs0), 0);

        // 5: count > DEPTH, with an ignored start pulse mid-sweep
        run_sweep("t5", 0, 7, 3);

        // 6: async reset in SEND_LO of the third word
        dn0 = done_cnt;
        start_i = 1'b1; base_addr_i = '0; count_i = CW'(5);
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t6.pre_valid", 32'(out_valid_o), 1);
        check("t6.pre_addr", 32'(out_addr_o), 2);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6.rst");
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();
        check_idle_outputs("t6.after");
        check("t6.no_done", 32'(done_cnt - dn0), 0);
        run_sweep("t6b", 1, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
Read-side sequencer for the 5-entry, 32-bit register-file memory. On a start command it sweeps a programmable address window using both read ports (A1 and A2), so it reads two words per access. It captures RD1/RD2 and streams the words out one at a time on a valid/ready interface, for debug dump and for checking the memory contents after the file is loaded. It never writes the memory.

Parameters:
DEPTH, 5, number of register-file entries; all addresses wrap modulo DEPTH
AW, 5, register-file address width
DW, 32, data word width
CW, 8, width of the word-count field

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  command pulse; sampled only in IDLE
base_addr  in  AW  first address to read; must be < DEPTH
count  in  CW  number of words to stream; 0 is legal
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the sweep completes
rf_a1  out  AW  register-file read address, port 1
rf_a2  out  AW  register-file read address, port 2
rf_rw  out  1  register-file write enable; constant 0
rf_rd1  in  DW  register-file read data, port 1 (registered, 1-cycle latency)
rf_rd2  in  DW  register-file read data, port 2
out_valid  out  1  stream word valid
out_ready  in  1  downstream accepts the word
out_data  out  DW  stream word
out_addr  out  AW  address the word was read from
out_last  out  1  high with the final word of the sweep

Behaviour:
- Reset (async): state IDLE; ptr=0; remaining=0; hold registers 0. All outputs 0: busy, done, rf_a1, rf_a2, rf_rw, out_valid, out_data, out_addr, out_last.
- Reset mid-sweep aborts the sweep immediately. No done pulse is produced.
- Internal state: ptr (AW bits), remaining (CW bits), hold1/hold2 (DW bits each).
- IDLE:
  - start=1 and count=0: go to DONE.
  - start=1 and count>0: ptr<=base_addr, remaining<=count, go to ISSUE.
  - start is ignored in every other state.
- ISSUE (1 cycle): rf_a1=ptr, rf_a2=(ptr+1) mod DEPTH. The register file samples these on the next edge. Go to CAPTURE.
- CAPTURE (1 cycle): rf_a1/rf_a2 held. hold1<=rf_rd1, hold2<=rf_rd2. Go to SEND_LO.
- SEND_LO: out_valid=1, out_data=hold1, out_addr=ptr, out_last=(remaining==1).
  - On handshake (out_valid & out_ready): remaining decrements.
  - If this was the last word, go to DONE; otherwise go to SEND_HI.
- SEND_HI: out_valid=1, out_data=hold2, out_addr=(ptr+1) mod DEPTH, out_last=(remaining==1).
  - On handshake: remaining decrements and ptr<=(ptr+2) mod DEPTH.
  - If this was the last word, go to DONE; otherwise go to ISSUE.
- DONE: done=1 for exactly one cycle; busy is still 1. Go to IDLE.
- Handshake rules:
  - Once out_valid is asserted, out_data, out_addr and out_last stay stable until the handshake.
  - out_valid never drops without a handshake, except on reset.
  - out_ready is ignored when out_valid=0.
- Latency: if start is sampled at edge E0, out_valid is first high after E2. With out_ready held high, throughput is 2 words per 4 cycles.
- Wrap-around: ptr+1 and ptr+2 are computed modulo DEPTH; with DEPTH=5, 4+1 gives 0 and 4+2 gives 1.
- If count > DEPTH, the sweep keeps wrapping and entries are reread. Words always appear in address order starting at base_addr.
- An odd count ends in SEND_LO; the HI word read in that access is discarded.
- rf_rw=0 at all times.

Test Plan:
All tests preload Mem[i]=32'h1000_0000+i (DEPTH=5) unless stated otherwise.
1. base=0, count=5, out_ready=1 -> 5 words 10000000..10000004 at addrs 0..4; first out_valid 2 edges after start; out_last only on addr 4; done pulses the cycle after the last handshake; busy falls with done.
2. base=3, count=4 -> addrs 3,4,0,1 with data 10000003,10000004,10000000,10000001; wrap is correct and out_last is on addr 1.
3. base=0, count=2; out_ready=0 for 3 cycles while in SEND_HI -> out_valid stays 1 and out_data stays 10000001 until ready returns; exactly 2 handshakes total.
4. count=0 -> done=1 exactly one cycle after start, out_valid never asserts, busy high for that single cycle.
5. base=0, count=7 -> addrs 0,1,2,3,4,0,1. A second start pulse issued mid-sweep is ignored (still 7 words).
6. Assert rst while in SEND_LO on the 3rd word -> all outputs 0 asynchronously, no done pulse. A later start with base=1, count=1 streams 10000001 with out_last=1.
